// File: rtl/spi_flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_loader
// Purpose  : Boot sequencer. Drives an SPI peripheral over its register port
//            to issue a serial-flash READ (0x03) at FLASH_ADDR and streams
//            BYTES received bytes into a local memory write port.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_loader #(
  parameter int          BYTES      = 256,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter int          MEM_AW     = 16,
  parameter int          TIMEOUT    = 4095
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              spi_ren,
  output logic [2:0]        spi_raddr,
  input  logic [7:0]        spi_rdata,
  output logic              spi_wen,
  output logic [2:0]        spi_waddr,
  output logic [7:0]        spi_wdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  localparam logic [11:0] C_TO_LIM    = 12'(TIMEOUT);
  localparam logic [15:0] C_BYTES_LIM = 16'(BYTES);
  localparam logic [2:0]  C_REG_DATA  = 3'h0;
  localparam logic [2:0]  C_REG_STAT  = 3'h1;
  localparam logic [2:0]  C_REG_CTRL  = 3'h2;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CS_ON    = 4'd1,
    SEND     = 4'd2,
    POLL_REQ = 4'd3,
    POLL_CHK = 4'd4,
    GET_REQ  = 4'd5,
    GET_CHK  = 4'd6,
    STORE    = 4'd7,
    CS_OFF   = 4'd8,
    FIN      = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         hdr_idx_q, hdr_idx_d;
  logic               hdr_done_q, hdr_done_d;
  logic [15:0]        pay_idx_q, pay_idx_d;
  logic [11:0]        poll_q, poll_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               spi_ren_q, spi_ren_d;
  logic [2:0]         spi_raddr_q, spi_raddr_d;
  logic               spi_wen_q, spi_wen_d;
  logic [2:0]         spi_waddr_q, spi_waddr_d;
  logic [7:0]         spi_wdata_q, spi_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic [7:0]         w_hdr_byte;

  // Header byte selected by the header index that will be current in SEND.
  always_comb begin
    w_hdr_byte = 8'h03;
    case (hdr_idx_d)
      2'd0:    w_hdr_byte = 8'h03;
      2'd1:    w_hdr_byte = FLASH_ADDR[23:16];
      2'd2:    w_hdr_byte = FLASH_ADDR[15:8];
      default: w_hdr_byte = FLASH_ADDR[7:0];
    endcase
  end

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    hdr_done_d = hdr_done_q;
    pay_idx_d  = pay_idx_q;
    poll_d     = poll_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CS_ON;
          err_d      = 1'b0;
          hdr_idx_d  = 2'd0;
          hdr_done_d = 1'b0;
          pay_idx_d  = 16'd0;
          poll_d     = 12'd0;
        end
      end
      CS_ON:    state_d = SEND;
      SEND:     state_d = POLL_REQ;
      POLL_REQ: state_d = POLL_CHK;
      POLL_CHK: begin
        if (spi_rdata[0]) begin
          poll_d = (poll_q >= C_TO_LIM) ? C_TO_LIM : poll_q + 12'd1;
          if (poll_d == C_TO_LIM) begin
            err_d   = 1'b1;
            state_d = CS_OFF;
          end else begin
            state_d = POLL_REQ;
          end
        end else begin
          poll_d = 12'd0;
          if (!hdr_done_q) begin
            // Last header byte acknowledged: next SEND is the first dummy byte.
            if (hdr_idx_q == 2'd3) hdr_done_d = 1'b1;
            else                   hdr_idx_d  = hdr_idx_q + 2'd1;
            state_d = SEND;
          end else begin
            state_d = GET_REQ;
          end
        end
      end
      GET_REQ: state_d = GET_CHK;
      GET_CHK: state_d = STORE;
      STORE: begin
        pay_idx_d = pay_idx_q + 16'd1;
        state_d   = (pay_idx_d == C_BYTES_LIM) ? CS_OFF : SEND;
      end
      CS_OFF:  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    busy_d      = (state_d != IDLE) && (state_d != FIN);
    done_d      = (state_d == FIN);
    spi_ren_d   = 1'b0;
    spi_raddr_d = 3'h0;
    spi_wen_d   = 1'b0;
    spi_waddr_d = 3'h0;
    spi_wdata_d = 8'h00;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = 8'h00;
    case (state_d)
      CS_ON: begin
        spi_wen_d   = 1'b1;
        spi_waddr_d = C_REG_CTRL;
        spi_wdata_d = 8'h01;
      end
      SEND: begin
        spi_wen_d   = 1'b1;
        spi_waddr_d = C_REG_DATA;
        spi_wdata_d = hdr_done_d ? 8'h00 : w_hdr_byte;
      end
      POLL_REQ: begin
        spi_ren_d   = 1'b1;
        spi_raddr_d = C_REG_STAT;
      end
      GET_REQ: begin
        spi_ren_d   = 1'b1;
        spi_raddr_d = C_REG_DATA;
      end
      STORE: begin
        // Entered only from GET_CHK, where spi_rdata holds the received byte.
        mem_we_d    = 1'b1;
        mem_addr_d  = MEM_AW'(pay_idx_q);
        mem_wdata_d = spi_rdata;
      end
      CS_OFF: begin
        spi_wen_d   = 1'b1;
        spi_waddr_d = C_REG_CTRL;
        spi_wdata_d = 8'h00;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      hdr_idx_q   <= 2'd0;
      hdr_done_q  <= 1'b0;
      pay_idx_q   <= 16'd0;
      poll_q      <= 12'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spi_ren_q   <= 1'b0;
      spi_raddr_q <= 3'h0;
      spi_wen_q   <= 1'b0;
      spi_waddr_q <= 3'h0;
      spi_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      hdr_done_q  <= hdr_done_d;
      pay_idx_q   <= pay_idx_d;
      poll_q      <= poll_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      spi_ren_q   <= spi_ren_d;
      spi_raddr_q <= spi_raddr_d;
      spi_wen_q   <= spi_wen_d;
      spi_waddr_q <= spi_waddr_d;
      spi_wdata_q <= spi_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign spi_ren   = spi_ren_q;
  assign spi_raddr = spi_raddr_q;
  assign spi_wen   = spi_wen_q;
  assign spi_waddr = spi_waddr_q;
  assign spi_wdata = spi_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_loader
// Purpose  : Directed self-checking bench for spi_flash_loader with a small
//            behavioural SPI peripheral per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_loader;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [1:0] start = 2'b00;
  logic [1:0] busy, done, err, spi_ren, spi_wen, mem_we;
  logic [2:0] spi_raddr [2];
  logic [2:0] spi_waddr [2];
  logic [7:0] spi_wdata [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] m_rdata   [2];
  logic [15:0] mem_addr0;
  logic [0:0]  mem_addr1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_flash_loader #(.BYTES(4), .FLASH_ADDR(24'h012345), .MEM_AW(16), .TIMEOUT(15)) u0 (
    .clk(clk), .n_rst(n_rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .spi_ren(spi_ren[0]), .spi_raddr(spi_raddr[0]), .spi_rdata(m_rdata[0]),
    .spi_wen(spi_wen[0]), .spi_waddr(spi_waddr[0]), .spi_wdata(spi_wdata[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr0), .mem_wdata(mem_wdata[0]));

  spi_flash_loader #(.BYTES(3), .FLASH_ADDR(24'h000000), .MEM_AW(1), .TIMEOUT(4095)) u1 (
    .clk(clk), .n_rst(n_rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .spi_ren(spi_ren[1]), .spi_raddr(spi_raddr[1]), .spi_rdata(m_rdata[1]),
    .spi_wen(spi_wen[1]), .spi_waddr(spi_waddr[1]), .spi_wdata(spi_wdata[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr1), .mem_wdata(mem_wdata[1]));

  // SPI peripheral model: busy for m_lat polls after each DATA write (or
  // forever when stuck); payload byte j reads back as 8'hA0 + j.
  int         m_lat   [2] = '{0, 0};
  bit         m_stuck [2] = '{0, 0};
  int         m_busy  [2];
  int         m_dw    [2];
  logic [7:0] m_last  [2];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k]  <= 0;
        m_dw[k]    <= 0;
        m_last[k]  <= 8'h00;
        m_rdata[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (spi_wen[k]) begin
          if (spi_waddr[k] == 3'h0) begin
            m_busy[k] <= m_lat[k];
            m_last[k] <= 8'hA0 + 8'(m_dw[k] - 4);
            m_dw[k]   <= m_dw[k] + 1;
          end else if (spi_waddr[k] == 3'h2 && spi_wdata[k] == 8'h01) begin
            m_dw[k] <= 0;
          end
        end
        if (spi_ren[k]) begin
          if (spi_raddr[k] == 3'h1) begin
            m_rdata[k] <= {7'b0, (m_stuck[k] || m_busy[k] > 0)};
            if (m_busy[k] > 0) m_busy[k] <= m_busy[k] - 1;
          end else begin
            m_rdata[k] <= m_last[k];
          end
        end
      end
    end
  end

  // Monitors, sampled on the falling edge.
  int          cyc = 0;
  logic [10:0] wlog [$];
  logic [23:0] mlog0 [$];
  int          mcyc [$];
  logic [0:0]  maddr1 [$];
  int          polls0 = 0;
  int          viol = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (spi_wen[0]) wlog.push_back({spi_waddr[0], spi_wdata[0]});
    if (mem_we[0]) begin
      mlog0.push_back({mem_addr0, mem_wdata[0]});
      mcyc.push_back(cyc);
    end
    if (spi_ren[0] && spi_raddr[0] == 3'h1) polls0++;
    if (mem_we[1]) maddr1.push_back(mem_addr1);
    for (int k = 0; k < 2; k++) begin
      if (32'(spi_ren[k]) + 32'(spi_wen[k]) + 32'(mem_we[k]) > 1) viol++;
      if (!spi_ren[k] && spi_raddr[k] != 3'h0) viol++;
      if (!spi_wen[k] && (spi_waddr[k] != 3'h0 || spi_wdata[k] != 8'h00)) viol++;
      if (!mem_we[k] && mem_wdata[k] != 8'h00) viol++;
    end
    if (!mem_we[0] && mem_addr0 != 16'h0) viol++;
    if (!mem_we[1] && mem_addr1 != 1'b0) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse (or hold) start, check the accept cycle, then wait for done.
  task automatic run_load(input int k, input bit hold, output logic err_at_accept,
                          output logic err_at_done);
    int n;
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    if (!hold) start[k] = 1'b0;
    chk("accept_busy", 32'(busy[k]), 32'd1);
    chk("accept_cs_on", {20'd0, spi_wen[k], spi_waddr[k], spi_wdata[k]}, 32'h00000A01);
    err_at_accept = err[k];
    err_at_done   = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done[k]) break;
    end
    start[k] = 1'b0;
    if (n == 3000) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      err_at_done = err[k];
      chk("done_busy_low", 32'(busy[k]), 32'd0);
      @(negedge clk);
      chk("done_single", 32'(done[k]), 32'd0);
    end
  endtask

  logic [10:0] exp_w [10] = '{11'h201, 11'h003, 11'h001, 11'h023, 11'h045,
                              11'h000, 11'h000, 11'h000, 11'h000, 11'h200};

  task automatic check_wseq(input string tag);
    chk({tag, "_nwrites"}, 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(exp_w[i]));
  endtask

  task automatic clear_logs();
    wlog.delete(); mlog0.delete(); mcyc.delete(); maddr1.delete();
    polls0 = 0;
  endtask

  logic ea, ed;
  int   sz;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs0", 32'({busy[0], done[0], err[0], spi_ren[0], spi_wen[0], mem_we[0]}), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load with 3 busy polls per byte.
    clear_logs();
    m_lat[0] = 3;
    run_load(0, 1'b0, ea, ed);
    check_wseq("basic");
    chk("basic_nmem", 32'(mlog0.size()), 32'd4);
    for (int i = 0; i < 4 && i < mlog0.size(); i++)
      chk($sformatf("basic_mem%0d", i), 32'(mlog0[i]), {8'd0, 16'(i), 8'hA0 + 8'(i)});
    chk("basic_err", 32'(ed), 32'd0);

    // start held high throughout: no restart, same write sequence.
    clear_logs();
    run_load(0, 1'b1, ea, ed);
    repeat (6) @(negedge clk);
    check_wseq("hold");
    chk("hold_idle", 32'(busy[0]), 32'd0);

    // Zero-latency SPI: 6 cycles between stores.
    clear_logs();
    m_lat[0] = 0;
    run_load(0, 1'b0, ea, ed);
    chk("zl_nmem", 32'(mcyc.size()), 32'd4);
    for (int i = 1; i < 4 && i < mcyc.size(); i++)
      chk($sformatf("zl_gap%0d", i), 32'(mcyc[i] - mcyc[i-1]), 32'd6);

    // Busy stuck: abort after 15 polls.
    clear_logs();
    m_stuck[0] = 1'b1;
    run_load(0, 1'b0, ea, ed);
    chk("to_polls", 32'(polls0), 32'd15);
    chk("to_err", 32'(ed), 32'd1);
    chk("to_nmem", 32'(mlog0.size()), 32'd0);
    chk("to_nwrites", 32'(wlog.size()), 32'd3);
    if (wlog.size() > 0) chk("to_cs_off", 32'(wlog[wlog.size()-1]), 32'h200);
    repeat (4) @(negedge clk);
    chk("to_err_sticky", 32'(err[0]), 32'd1);
    m_stuck[0] = 1'b0;
    run_load(0, 1'b0, ea, ed);
    chk("to_err_cleared", 32'(ea), 32'd0);
    chk("to_err_after", 32'(ed), 32'd0);

    // Reset during the third payload byte.
    clear_logs();
    m_lat[0] = 3;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 0; n < 500 && mlog0.size() < 2; n++) @(negedge clk);
    chk("rst_reached", 32'(mlog0.size()), 32'd2);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1 chk("rst_async_outs",
           {5'd0, busy[0], done[0], err[0], spi_ren[0], spi_raddr[0], spi_wen[0], spi_waddr[0],
            spi_wdata[0], mem_we[0], mem_wdata[0]}, 32'd0);
    chk("rst_async_addr", 32'(mem_addr0), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    sz = wlog.size();
    repeat (8) @(negedge clk);
    chk("rst_stay_idle", 32'(busy[0]), 32'd0);
    chk("rst_no_writes", 32'(wlog.size()), 32'(sz));
    clear_logs();
    m_lat[0] = 0;
    run_load(0, 1'b0, ea, ed);
    chk("rst_reload_n", 32'(mlog0.size()), 32'd4);
    if (mlog0.size() > 0) chk("rst_reload_first", 32'(mlog0[0]), 32'h0000A0);

    // BYTES=3, MEM_AW=1: addresses wrap 0,1,0.
    clear_logs();
    m_lat[1] = 1;
    run_load(1, 1'b0, ea, ed);
    chk("wrap_n", 32'(maddr1.size()), 32'd3);
    for (int i = 0; i < 3 && i < maddr1.size(); i++)
      chk($sformatf("wrap_addr%0d", i), 32'(maddr1[i]), 32'(i % 2));

    chk("strobe_rules", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
